xform_bank_pipe: RTL and testbench

- Parametrised successor to the team's single-array transform test block.
- Accepts a valid/ready sample stream and applies a phase-dependent arithmetic transform: mod 5, square, half, quarter or zero.
- Writes each result into a DEPTH-entry slot bank and emits it on a valid/ready output, with an independent registered read-back port.
- Sits in the grammar/concolic test harness as a stress target for counters, handshakes and memory.

---
 rtl/xform_bank_pipe.sv | 140 ++++++++++++++
 tb/tb_xform_bank_pipe.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xform_bank_pipe.sv
// Two-stage valid/ready transform pipe: phase-selected transform written into a slot bank, plus a registered read-back port.
// Build option XFORM_SAT_EN: the SEED square saturates to all-ones instead of wrapping.
module xform_bank_pipe #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8,
    parameter int TH0   = 4,
    parameter int TH1   = 128,
    parameter int TH2   = 192,
    localparam int SLOT_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic [SLOT_W-1:0] out_slot,
    output logic [1:0]        out_mode,
    input  logic              rd_en,
    input  logic [SLOT_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    // Thresholds may equal 2^CNT_W, so compare with one extra bit.
    localparam logic [CNT_W:0] TH0_V = (CNT_W+1)'(TH0);
    localparam logic [CNT_W:0] TH1_V = (CNT_W+1)'(TH1);
    localparam logic [CNT_W:0] TH2_V = (CNT_W+1)'(TH2);

    logic                adv;
    logic                accept;
    logic [SLOT_W-1:0]   slot_ptr;
    logic [CNT_W-1:0]    phase;

    logic                s1_valid;
    logic [WIDTH-1:0]    s1_data;
    logic [SLOT_W-1:0]   s1_slot;
    logic [CNT_W-1:0]    s1_phase;

    logic [CNT_W:0]      phase_ext;
    logic [2*WIDTH-1:0]  sq_full;
    logic [WIDTH-1:0]    sq;
    logic [WIDTH-1:0]    x_result;
    logic [1:0]          x_mode;

    logic [WIDTH-1:0]    bank [DEPTH];

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv && !clr;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot_ptr <= '0;
            phase    <= '0;
        end else if (clr) begin
            slot_ptr <= '0;
            phase    <= '0;
        end else if (accept) begin
            slot_ptr <= slot_ptr + 1'b1;
            phase    <= phase + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_slot  <= '0;
            s1_phase <= '0;
        end else if (clr) begin
            s1_valid <= 1'b0;
        end else if (adv) begin
            s1_valid <= in_valid;
            s1_data  <= in_data;
            s1_slot  <= slot_ptr;
            s1_phase <= phase;
        end
    end

    assign phase_ext = {1'b0, s1_phase};
    assign sq_full   = {{WIDTH{1'b0}}, s1_data} * {{WIDTH{1'b0}}, s1_data};

`ifdef XFORM_SAT_EN
    assign sq = (|sq_full[2*WIDTH-1:WIDTH]) ? '1 : sq_full[WIDTH-1:0];
`else
    assign sq = sq_full[WIDTH-1:0];
`endif

    always_comb begin
        x_mode   = 2'd3;
        x_result = '0;
        if (phase_ext < TH0_V) begin
            x_mode   = 2'd0;
            x_result = s1_slot[0] ? sq : (s1_data % WIDTH'(5));
        end else if (phase_ext < TH1_V) begin
            x_mode   = 2'd1;
            x_result = s1_data >> 1;
        end else if (phase_ext < TH2_V) begin
            x_mode   = 2'd2;
            x_result = s1_data >> 2;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_slot  <= '0;
            out_mode  <= '0;
            for (int i = 0; i < DEPTH; i++) bank[i] <= '0;
        end else if (clr) begin
            out_valid <= 1'b0;
            for (int i = 0; i < DEPTH; i++) bank[i] <= '0;
        end else if (adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data       <= x_result;
                out_slot       <= s1_slot;
                out_mode       <= x_mode;
                bank[s1_slot]  <= x_result;
            end
        end
    end

    // Reads sample the bank before this edge's write lands.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data <= '0;
        end else if (clr) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= bank[rd_addr];
        end
    end

endmodule

// File: tb/tb_xform_bank_pipe.sv
// Scoreboard bench for xform_bank_pipe: reference results queued at accept time, popped by an output monitor.
module tb_xform_bank_pipe;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        clr = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic [1:0]  out_slot;
    logic [1:0]  out_mode;
    logic        rd_en = 1'b0;
    logic [1:0]  rd_addr = '0;
    logic [31:0] rd_data;

    xform_bank_pipe dut (
        .clk(clk), .reset(reset), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_slot(out_slot), .out_mode(out_mode),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  slot;
        logic [1:0]  mode;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    int          out_count = 0;
    int          m_phase = 0;
    int          m_slot = 0;
    logic [31:0] mbank [4];
    logic [31:0] held;
    logic [31:0] old_val;
    logic [31:0] rnd_d;
    logic        done = 1'b0;
    int          c0;

    function automatic exp_t model(input logic [31:0] d, input int ph, input int sl);
        exp_t        e;
        logic [63:0] p;
        e.slot = 2'(sl);
        if (ph < 4) begin
            e.mode = 2'd0;
            if (sl % 2 == 0) begin
                e.data = d % 5;
            end else begin
                p = 64'(d) * 64'(d);
`ifdef XFORM_SAT_EN
                e.data = (p > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : p[31:0];
`else
                e.data = p[31:0];
`endif
            end
        end else if (ph < 128) begin
            e.mode = 2'd1;
            e.data = d / 2;
        end else if (ph < 192) begin
            e.mode = 2'd2;
            e.data = d / 4;
        end else begin
            e.mode = 2'd3;
            e.data = 32'd0;
        end
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_slot  = 0;
        for (int i = 0; i < 4; i++) mbank[i] = '0;
        sb.delete();
    endtask

    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            out_count++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL out_unexpected actual=%0h expected=none", out_data);
            end else begin
                mon_e = sb.pop_front();
                chk("out_data", {32'd0, out_data}, {32'd0, mon_e.data});
                chk("out_slot", {62'd0, out_slot}, {62'd0, mon_e.slot});
                chk("out_mode", {62'd0, out_mode}, {62'd0, mon_e.mode});
            end
        end
    end

    task automatic send(input logic [31:0] d);
        exp_t e;
        int   n = 0;
        in_valid = 1'b1;
        in_data  = d;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 2000) begin
                checks++;
                errors++;
                $display("FAIL send_timeout actual=stalled expected=accept");
                in_valid = 1'b0;
                return;
            end
        end
        e = model(d, m_phase, m_slot);
        sb.push_back(e);
        mbank[m_slot] = e.data;
        m_phase = (m_phase + 1) % 256;
        m_slot  = (m_slot + 1) % 4;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        chk("drain_left", 64'(sb.size()), 64'd0);
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string name);
        rd_en   = 1'b1;
        rd_addr = a;
        @(posedge clk);
        #1 rd_en = 1'b0;
        chk(name, {32'd0, rd_data}, {32'd0, exp});
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_rd_data", {32'd0, rd_data}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        for (int i = 0; i < 4; i++) rd(2'(i), 32'd0, "rst_bank");

        // first two samples, fixed latency
        out_ready = 1'b1;
        send(32'd17);
        chk("lat_not_early", {63'd0, out_valid}, 64'd0);
        @(posedge clk);
        #1;
        chk("lat_valid", {63'd0, out_valid}, 64'd1);
        chk("first_data", {32'd0, out_data}, 64'd2);
        send(32'd70000);
        @(posedge clk);
        #1;
`ifdef XFORM_SAT_EN
        chk("second_data", {32'd0, out_data}, 64'hFFFF_FFFF);
`else
        chk("second_data", {32'd0, out_data}, 64'd605032704);
`endif
        send(32'd5);
        send(32'd6);
        drain();

        // backpressure with five samples at phases 4..8
        out_ready = 1'b0;
        c0 = out_count;
        fork
            repeat (5) send(32'd100);
            begin
                repeat (4) @(posedge clk);
                #2;
                chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
                held = out_data;
                repeat (3) @(posedge clk);
                #2;
                chk("bp_hold", {32'd0, out_data}, {32'd0, held});
                chk("bp_valid", {63'd0, out_valid}, 64'd1);
                out_ready = 1'b1;
            end
        join
        drain();
        chk("bp_count", 64'(out_count - c0), 64'd5);

        // randomized stream with random backpressure
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    rnd_d = $urandom;
                    if ($urandom_range(0, 3) == 0) rnd_d = 32'($urandom_range(0, 100000));
                    send(rnd_d);
                    if ($urandom_range(0, 2) == 0) begin
                        repeat ($urandom_range(1, 3)) @(posedge clk);
                        #1;
                    end
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1 out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        drain();
        for (int i = 0; i < 4; i++) rd(2'(i), mbank[i], "rand_bank");

        // phase sweep from reset
        reset = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        c0 = out_count;
        for (int i = 0; i < 257; i++) send(32'h400);
        drain();
        chk("sweep_count", 64'(out_count - c0), 64'd257);
        chk("sweep_last_data", {32'd0, out_data}, 64'd4);
        chk("sweep_last_slot", {62'd0, out_slot}, 64'd0);

        // read-before-write and clear
        send(32'd1);
        send(32'd9);
        drain();
        rd(2'd2, 32'd4, "rd_slot2");
        send(32'd1);
        send(32'd1);
        send(32'd1);
        drain();
        old_val = mbank[2];
        send(32'd50);
        rd(2'd2, old_val, "rd_before_write");
        rd(2'd2, 32'd25, "rd_after_write");
        drain();
        clr = 1'b1;
        #1;
        chk("clr_in_ready", {63'd0, in_ready}, 64'd0);
        @(posedge clk);
        #1 clr = 1'b0;
        model_reset();
        chk("clr_out_valid", {63'd0, out_valid}, 64'd0);
        chk("clr_rd_data", {32'd0, rd_data}, 64'd0);
        for (int i = 0; i < 4; i++) rd(2'(i), 32'd0, "clr_bank");
        send(32'd17);
        @(posedge clk);
        #1;
        chk("clr_next_slot", {62'd0, out_slot}, 64'd0);
        chk("clr_next_mode", {62'd0, out_mode}, 64'd0);
        chk("clr_next_data", {32'd0, out_data}, 64'd2);
        drain();

        // reset with samples in flight
        out_ready = 1'b0;
        send(32'd3);
        send(32'd4);
        reset = 1'b0;
        #1;
        chk("mid_rst_valid", {63'd0, out_valid}, 64'd0);
        model_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        out_ready = 1'b1;
        chk("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("mid_rst_quiet", {63'd0, out_valid}, 64'd0);
        rd(2'd1, 32'd0, "mid_rst_bank");

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
